// File: rtl/fir_tap_pingpong_buffer.sv
// Double-buffered FIR tap loader: serial h stream in, parallel tap vector out.
// Optional FIR_TAP_BUFFER_REVERSE_EN stores serial tap k in slot len-1-k.
module fir_tap_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_TAPS   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic [$clog2(MAX_TAPS):0]            nb_taps_i,
  input  logic                                 h_serial_valid,
  output logic                                 h_serial_ready,
  input  logic [DATA_WIDTH-1:0]                h_serial_data,
  output logic                                 h_parallel_valid,
  input  logic                                 h_parallel_ready,
  output logic [DATA_WIDTH*MAX_TAPS-1:0]       h_parallel_data,
  output logic [$clog2(MAX_TAPS):0]            active_taps_o
);

  localparam int unsigned CW = $clog2(MAX_TAPS) + 1;
  localparam int unsigned WW = $clog2(MAX_TAPS);
  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_TAPS);

  logic [DATA_WIDTH-1:0] taps_q [2][MAX_TAPS];
  logic [CW-1:0]         len_q [2];
  logic [1:0]            full_q;
  logic                  act_q;
  logic                  pending_q;
  logic [WW-1:0]         wcnt_q;
  logic [CW-1:0]         len_set_q;

  logic          ld;
  logic          hs;
  logic          swap;
  logic          last;
  logic [CW-1:0] nb_clamp;
  logic [CW-1:0] len_load;
  logic [WW-1:0] slot;

  assign ld = ~act_q;

  always_comb begin
    nb_clamp = nb_taps_i;
    if (nb_taps_i == '0 || nb_taps_i > MAX_LEN) nb_clamp = MAX_LEN;
  end

  // Length is frozen after the first tap so mid-set changes are ignored
  assign len_load = (wcnt_q == '0) ? nb_clamp : len_set_q;
  assign last     = ({1'b0, wcnt_q} == len_load - CW'(1));

`ifdef FIR_TAP_BUFFER_REVERSE_EN
  assign slot = WW'(len_load - CW'(1) - {1'b0, wcnt_q});
`else
  assign slot = wcnt_q;
`endif

  assign h_serial_ready   = ~pending_q;
  assign hs               = h_serial_valid & h_serial_ready;
  assign h_parallel_valid = full_q[act_q];
  assign swap = pending_q & (~h_parallel_valid | h_parallel_ready);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAX_TAPS; i++) begin
          taps_q[b][i] <= '0;
        end
        len_q[b] <= '0;
      end
      full_q    <= '0;
      act_q     <= 1'b0;
      pending_q <= 1'b0;
      wcnt_q    <= '0;
      len_set_q <= '0;
    end else begin
      if (hs) begin
        taps_q[ld][slot] <= h_serial_data;
        if (wcnt_q == '0) len_set_q <= nb_clamp;
        if (last) begin
          pending_q <= 1'b1;
          wcnt_q    <= '0;
          len_q[ld] <= len_load;
        end else begin
          wcnt_q <= wcnt_q + WW'(1);
        end
      end
      // hs and swap are exclusive: hs needs ~pending_q, swap needs pending_q
      if (swap) begin
        act_q         <= ~act_q;
        full_q[ld]    <= 1'b1;
        full_q[act_q] <= 1'b0;
        pending_q     <= 1'b0;
      end
    end
  end

  always_comb begin
    h_parallel_data = '0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (full_q[act_q] && (CW'(i) < len_q[act_q])) begin
        h_parallel_data[i*DATA_WIDTH +: DATA_WIDTH] = taps_q[act_q][i];
      end
    end
  end

  assign active_taps_o = full_q[act_q] ? len_q[act_q] : '0;

endmodule
